fpu_alu_scheduler: RTL

//   Shares one 32-bit single-precision alu (ports clk/A/B/OpCode/O) between NUM_REQ requesters.

---
 rtl/fpu_alu_scheduler.sv | 102 ++++++++++
 1 files changed

// File: rtl/fpu_alu_scheduler.sv
// fpu_alu_scheduler: round-robin sharing of one pipelined fp alu among NUM_REQ requesters.
// Optional ALU_SCHED_PRIO_EN: requester 0 priority with a 4-grant starvation guard.
module fpu_alu_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ALU_LAT = 2,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [3*NUM_REQ-1:0]  req_op,
   input  logic                  hold,
   output logic [31:0]           alu_A,
   output logic [31:0]           alu_B,
   output logic [2:0]            alu_OpCode,
   input  logic [31:0]           alu_O,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_data,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t                    state;
   logic [IDW-1:0]            ptr, gid;
   logic [ALU_LAT:0]          vld;
   logic [ALU_LAT:0][IDW-1:0] ids;
   logic [IDW:0]              rr;
   logic                      gv, acc, pipe;

   // first set bit of m scanning upward from p with wrap; msb of result flags a hit
   function automatic logic [IDW:0] pick(input logic [NUM_REQ-1:0] m, input logic [IDW-1:0] p);
      logic [IDW:0]   r;
      logic [IDW-1:0] i;
      r = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         i = IDW'((int'(p) + k) % NUM_REQ);
         if (m[i]) r = {1'b1, i};
      end
      return r;
   endfunction

`ifdef ALU_SCHED_PRIO_EN
   logic [2:0] cnt;
   logic       others, starve, pri;
   always_comb begin
      others = |req_valid[NUM_REQ-1:1];
      starve = cnt == 3'd4 && others;
      pri    = req_valid[0] && !starve;
      rr     = pick(starve ? req_valid & ~NUM_REQ'(1) : req_valid, ptr);
      gv     = pri || rr[IDW];
      gid    = pri ? '0 : rr[IDW-1:0];
   end
   always_ff @(posedge clk)
      if (!rst_n) cnt <= '0;
      else if (acc) cnt <= (pri && others) ? cnt + 3'd1 : '0;
`else
   always_comb begin
      rr  = pick(req_valid, ptr);
      gv  = rr[IDW];
      gid = rr[IDW-1:0];
   end
`endif

   assign pipe      = |vld;
   assign req_ready = (rst_n && gv && !hold && state != DRAIN) ? NUM_REQ'(1) << gid : '0;
   assign acc       = |(req_valid & req_ready);
   assign busy      = pipe || |rsp_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         vld        <= '0;
         ids        <= '0;
         alu_A      <= '0;
         alu_B      <= '0;
         alu_OpCode <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
      end else begin
         vld       <= {vld[ALU_LAT-1:0], acc};
         ids       <= {ids[ALU_LAT-1:0], gid};
         rsp_valid <= vld[ALU_LAT] ? NUM_REQ'(1) << ids[ALU_LAT] : '0;
         if (vld[ALU_LAT]) rsp_data <= alu_O;
         if (acc) begin
            ptr        <= IDW'((int'(gid) + 1) % NUM_REQ);
            alu_A      <= req_a[32*gid +: 32];
            alu_B      <= req_b[32*gid +: 32];
            alu_OpCode <= req_op[3*gid +: 3];
         end
         case (state)
            IDLE:    if (acc) state <= RUN;
            RUN:     if (!pipe && !acc) state <= IDLE;
                     else if (hold && pipe) state <= DRAIN;
            DRAIN:   if (!pipe) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
